set_key_ctrl: RTL and testbench

- Front-end control stage for the multi-mode clock's time-setting path, sitting directly upstream of the time-set block.
- Debounces four raw push-buttons (mode, select, up, down) and runs the RUN/SET mode state machine.
- Produces the set_sign / en / leave / signal_increase / signal_decrease strobes that the time-set block consumes. Up/down keys auto-repeat while held.
- Runs on the fast clock.

---
 rtl/set_key_ctrl_pkg.sv | 42 ++++
 rtl/set_key_ctrl_if.sv | 25 ++
 rtl/set_key_ctrl_debounce.sv | 58 +++++
 rtl/set_key_ctrl.sv | 135 +++++++++++++
 tb/tb_set_key_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/set_key_ctrl_pkg.sv
// Shared types and constants for the time-setting key front end.
package set_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ENTER = 2'd1,
        SET   = 2'd2,
        EXIT  = 2'd3
    } state_e;

    localparam logic [1:0] FIELD_HOUR = 2'd2;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_SEC  = 2'd0;

    localparam int unsigned KEY_MODE = 0;
    localparam int unsigned KEY_SEL  = 1;
    localparam int unsigned KEY_UP   = 2;
    localparam int unsigned KEY_DOWN = 3;
    localparam int unsigned KEY_NUM  = 4;

    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [1:0] next_field(input logic [1:0] f);
        unique case (f)
            FIELD_HOUR: return FIELD_MIN;
            FIELD_MIN:  return FIELD_SEC;
            default:    return FIELD_HOUR;
        endcase
    endfunction

    function automatic logic [2:0] field_onehot(input logic [1:0] f);
        unique case (f)
            FIELD_HOUR: return 3'b100;
            FIELD_MIN:  return 3'b010;
            FIELD_SEC:  return 3'b001;
            default:    return '0;
        endcase
    endfunction

endpackage

// File: rtl/set_key_ctrl_if.sv
// Key inputs and time-set strobes between the button panel and set_key_ctrl.
interface set_key_ctrl_if;

    logic       key_mode;
    logic       key_sel;
    logic       key_up;
    logic       key_down;
    logic       set_sign;
    logic       en;
    logic       leave;
    logic [2:0] signal_increase;
    logic [2:0] signal_decrease;
    logic [1:0] field_sel;

    modport master (
        output key_mode, key_sel, key_up, key_down,
        input  set_sign, en, leave, signal_increase, signal_decrease, field_sel
    );

    modport slave (
        input  key_mode, key_sel, key_up, key_down,
        output set_sign, en, leave, signal_increase, signal_decrease, field_sel
    );

endinterface

// File: rtl/set_key_ctrl_debounce.sv
// One push-button: 2-flop synchroniser, stability counter, 1-cycle press pulse
// on the registered rising edge of the debounced level.
module key_debounce
    import set_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CW = cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised key disagrees with the level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= key_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            cnt_q       <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/set_key_ctrl.sv
// RUN/SET mode controller: debounced keys, field select, inc/dec strobes with
// auto-repeat, and idle auto-exit for the downstream time-set block.
module set_key_ctrl
    import set_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 20000,
    parameter int unsigned REPEAT_DELAY  = 500000,
    parameter int unsigned REPEAT_PERIOD = 100000,
    parameter int unsigned IDLE_TIMEOUT  = 10000000
) (
    input logic           clk,
    input logic           rst_n,
    set_key_ctrl_if.slave bus
);

    localparam int unsigned RW = cnt_w(REPEAT_DELAY);
    localparam int unsigned IW = cnt_w(IDLE_TIMEOUT);
    localparam logic [RW-1:0] REP_FIRE   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TIMEOUT);

    logic [KEY_NUM-1:0] lvl, prs;
    logic               unused_lvl;

    state_e        state_q, state_d;
    logic [1:0]    field_q, field_d;
    logic [2:0]    inc_q, inc_d, dec_q, dec_d;
    logic [RW-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          set_sign_q, en_q, leave_q;
    logic          up_act, dn_act, up_fire, dn_fire;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk(clk), .rst_n(rst_n), .key_i(bus.key_mode),
        .level_o(lvl[KEY_MODE]), .press_o(prs[KEY_MODE])
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
        .clk(clk), .rst_n(rst_n), .key_i(bus.key_sel),
        .level_o(lvl[KEY_SEL]), .press_o(prs[KEY_SEL])
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk(clk), .rst_n(rst_n), .key_i(bus.key_up),
        .level_o(lvl[KEY_UP]), .press_o(prs[KEY_UP])
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
        .clk(clk), .rst_n(rst_n), .key_i(bus.key_down),
        .level_o(lvl[KEY_DOWN]), .press_o(prs[KEY_DOWN])
    );

    assign unused_lvl = ^{lvl[KEY_MODE], lvl[KEY_SEL]};

    always_comb begin
        state_d  = state_q;
        field_d  = field_q;
        inc_d    = '0;
        dec_d    = '0;
        up_cnt_d = '0;
        dn_cnt_d = '0;
        idle_d   = '0;

        // Repeat counters run only for a lone held key in SET; a press restarts
        // the count at 1 so the first repeat lands REPEAT_DELAY after the press.
        up_act  = (state_q == SET) && lvl[KEY_UP] && !lvl[KEY_DOWN];
        dn_act  = (state_q == SET) && lvl[KEY_DOWN] && !lvl[KEY_UP];
        up_fire = up_act && (prs[KEY_UP] || (up_cnt_q == REP_FIRE));
        dn_fire = dn_act && (prs[KEY_DOWN] || (dn_cnt_q == REP_FIRE));

        if (up_act) begin
            if (prs[KEY_UP])                up_cnt_d = RW'(1);
            else if (up_cnt_q == REP_FIRE)  up_cnt_d = REP_RELOAD;
            else                            up_cnt_d = up_cnt_q + 1'b1;
        end
        if (dn_act) begin
            if (prs[KEY_DOWN])              dn_cnt_d = RW'(1);
            else if (dn_cnt_q == REP_FIRE)  dn_cnt_d = REP_RELOAD;
            else                            dn_cnt_d = dn_cnt_q + 1'b1;
        end

        unique case (state_q)
            RUN: begin
                if (prs[KEY_MODE]) begin
                    state_d = ENTER;
                    field_d = FIELD_HOUR;
                end
            end
            ENTER: state_d = SET;
            SET: begin
                if ((|prs) || up_fire || dn_fire) idle_d = '0;
                else if (idle_q != IDLE_MAX)      idle_d = idle_q + 1'b1;
                else                              idle_d = idle_q;

                if (prs[KEY_MODE] || (idle_q == IDLE_MAX)) state_d = EXIT;
                else if (prs[KEY_SEL])                     field_d = next_field(field_q);
                else if (up_fire)                          inc_d   = field_onehot(field_q);
                else if (dn_fire)                          dec_d   = field_onehot(field_q);
            end
            EXIT: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            field_q    <= FIELD_HOUR;
            inc_q      <= '0;
            dec_q      <= '0;
            up_cnt_q   <= '0;
            dn_cnt_q   <= '0;
            idle_q     <= '0;
            set_sign_q <= 1'b0;
            en_q       <= 1'b0;
            leave_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            field_q    <= field_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            up_cnt_q   <= up_cnt_d;
            dn_cnt_q   <= dn_cnt_d;
            idle_q     <= idle_d;
            set_sign_q <= (state_d == ENTER);
            en_q       <= (state_d == SET);
            leave_q    <= (state_d == EXIT);
        end
    end

    assign bus.set_sign        = set_sign_q;
    assign bus.en              = en_q;
    assign bus.leave           = leave_q;
    assign bus.signal_increase = inc_q;
    assign bus.signal_decrease = dec_q;
    assign bus.field_sel       = field_q;

endmodule

// File: tb/tb_set_key_ctrl.sv
// Directed bench for set_key_ctrl with short debounce/repeat/idle parameters.
module tb_set_key_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 16;
    localparam int unsigned RP = 4;
    localparam int unsigned IT = 64;

    localparam logic [3:0] K_MODE = 4'b0001;
    localparam logic [3:0] K_SEL  = 4'b0010;
    localparam logic [3:0] K_UP   = 4'b0100;
    localparam logic [3:0] K_DOWN = 4'b1000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned ss_cyc[$];
    int unsigned lv_cyc[$];
    int unsigned inc_cyc[$];
    int unsigned inc_val[$];
    int unsigned dec_cyc[$];
    int unsigned dec_val[$];
    int unsigned en_rise = 0;
    logic        en_prev = 1'b0;

    set_key_ctrl_if bus ();

    set_key_ctrl #(
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .IDLE_TIMEOUT (IT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge, tagged with the posedge count.
    always @(negedge clk) begin
        if (bus.set_sign) ss_cyc.push_back(cyc);
        if (bus.leave)    lv_cyc.push_back(cyc);
        if (bus.signal_increase != 3'b000) begin
            inc_cyc.push_back(cyc);
            inc_val.push_back(int'(bus.signal_increase));
        end
        if (bus.signal_decrease != 3'b000) begin
            dec_cyc.push_back(cyc);
            dec_val.push_back(int'(bus.signal_decrease));
        end
        if (bus.en && !en_prev) en_rise = cyc;
        en_prev = bus.en;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned q_at(input int unsigned q[$], input int unsigned i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] m);
        bus.key_mode = m[0];
        bus.key_sel  = m[1];
        bus.key_up   = m[2];
        bus.key_down = m[3];
    endtask

    task automatic pulse(input logic [3:0] m, input int unsigned hold);
        drive(m);
        tick(hold);
        drive(4'b0000);
    endtask

    task automatic clear_logs();
        ss_cyc.delete();
        lv_cyc.delete();
        inc_cyc.delete();
        inc_val.delete();
        dec_cyc.delete();
        dec_val.delete();
    endtask

    // Raw key raised at cycle t gives a press event at t+7 and a strobe at t+8.
    int unsigned t;
    int unsigned rep_off[7] = '{8, 24, 28, 32, 36, 40, 44};

    initial begin
        drive(4'b0000);
        rst_n = 1'b0;
        tick(3);
        check("rst_en",     bus.en, 0);
        check("rst_field",  bus.field_sel, 2);
        check("rst_pulses", {bus.set_sign, bus.leave, bus.signal_increase, bus.signal_decrease}, 0);
        rst_n = 1'b1;
        tick(3);
        clear_logs();

        // Enter and leave SET with the mode key
        t = cyc;
        pulse(K_MODE, 10);
        tick(10);
        check("enter_ss_count", ss_cyc.size(), 1);
        check("enter_ss_time",  q_at(ss_cyc, 0) - t, 8);
        check("enter_en_time",  en_rise - t, 9);
        check("enter_en",       bus.en, 1);
        check("enter_field",    bus.field_sel, 2);
        t = cyc;
        pulse(K_MODE, 10);
        tick(10);
        check("exit_lv_count", lv_cyc.size(), 1);
        check("exit_lv_time",  q_at(lv_cyc, 0) - t, 8);
        check("exit_en",       bus.en, 0);

        // Glitchy up key is rejected, a clean press strobes the hour field
        pulse(K_MODE, 10);
        tick(10);
        clear_logs();
        repeat (4) begin
            drive(K_UP);
            tick(3);
            drive(4'b0000);
            tick(1);
        end
        tick(8);
        check("glitch_inc_count", inc_cyc.size(), 0);
        t = cyc;
        pulse(K_UP, 10);
        tick(10);
        check("up_inc_count", inc_cyc.size(), 1);
        check("up_inc_val",   q_at(inc_val, 0), 3'b100);
        check("up_inc_time",  q_at(inc_cyc, 0) - t, 8);

        // Field select walk and a decrement on seconds
        clear_logs();
        pulse(K_SEL, 10);
        tick(10);
        check("sel1_field", bus.field_sel, 1);
        pulse(K_SEL, 10);
        tick(10);
        check("sel2_field", bus.field_sel, 0);
        t = cyc;
        pulse(K_DOWN, 10);
        tick(10);
        check("dn_dec_count", dec_cyc.size(), 1);
        check("dn_dec_val",   q_at(dec_val, 0), 3'b001);
        check("dn_dec_time",  q_at(dec_cyc, 0) - t, 8);
        check("dn_inc_count", inc_cyc.size(), 0);
        pulse(K_SEL, 10);
        tick(10);
        check("sel3_field", bus.field_sel, 2);

        // Auto-repeat on minutes: press+0, then +16, +20 ... +36
        pulse(K_SEL, 10);
        tick(10);
        check("rep_field", bus.field_sel, 1);
        clear_logs();
        t = cyc;
        pulse(K_UP, 40);
        tick(20);
        check("rep_count", inc_cyc.size(), 7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("rep_time%0d", i), q_at(inc_cyc, i) - t, rep_off[i]);
        end
        check("rep_val_first", q_at(inc_val, 0), 3'b010);
        check("rep_val_last",  q_at(inc_val, 6), 3'b010);
        check("rep_dec_count", dec_cyc.size(), 0);

        // Up and down together are suppressed; mode wins over a coincident up
        clear_logs();
        pulse(K_UP | K_DOWN, 30);
        tick(20);
        check("both_inc_count", inc_cyc.size(), 0);
        check("both_dec_count", dec_cyc.size(), 0);
        clear_logs();
        t = cyc;
        pulse(K_MODE | K_UP, 10);
        tick(10);
        check("modeup_lv_count",  lv_cyc.size(), 1);
        check("modeup_lv_time",   q_at(lv_cyc, 0) - t, 8);
        check("modeup_inc_count", inc_cyc.size(), 0);
        check("modeup_en",        bus.en, 0);

        // Idle timeout: en high for IT+1 cycles, then a single leave pulse
        clear_logs();
        pulse(K_MODE, 10);
        tick(100);
        check("idle_lv_count", lv_cyc.size(), 1);
        check("idle_lv_time",  q_at(lv_cyc, 0) - en_rise, 65);
        check("idle_en",       bus.en, 0);
        check("idle_ss_count", ss_cyc.size(), 1);

        // Reset in SET drops en without a leave pulse and restores hour field
        pulse(K_MODE, 10);
        tick(10);
        pulse(K_SEL, 10);
        tick(10);
        check("pre_rst_en",    bus.en, 1);
        check("pre_rst_field", bus.field_sel, 1);
        clear_logs();
        rst_n = 1'b0;
        tick(2);
        check("mid_rst_en", bus.en, 0);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_en",       bus.en, 0);
        check("post_rst_field",    bus.field_sel, 2);
        check("post_rst_lv_count", lv_cyc.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
